// File: rtl/panda_pkg.sv
// ---------------------------------------------------------------------------
// panda_pkg
// Shared types for the Panda ID/EX operand stage.
//   src_sel_e : which path supplied a resolved operand (zero register,
//               execute bypass, writeback bypass or register file read).
// ---------------------------------------------------------------------------
package panda_pkg;

    typedef enum logic [1:0] {
        SrcZero = 2'd0,
        SrcEx   = 2'd1,
        SrcWb   = 2'd2,
        SrcRf   = 2'd3
    } src_sel_e;

endpackage : panda_pkg

// File: rtl/panda_operand_stage_if.sv
// ---------------------------------------------------------------------------
// panda_operand_stage_if
// Bundle between the operand stage (master) and the execute stage (slave).
// Handshake: a transfer happens on a rising clock edge where valid_o and
// ready_i are both high. While valid_o is high and ready_i is low, the
// master keeps every payload field stable; valid_o never drops without a
// transfer except on flush or reset.
//   valid_o     : payload holds a live instruction
//   ready_i     : execute accepts the payload this cycle
//   rs1_value_o : resolved operand 1
//   rs2_value_o : resolved operand 2
//   imm_o       : immediate
//   pc_o        : instruction PC
//   rd_addr_o   : destination register index
//   is_load_o   : instruction is a load
// ---------------------------------------------------------------------------
interface panda_operand_stage_if #(
    parameter int Width = 32,
    parameter int Depth = 32
);
    localparam int AddrW = $clog2(Depth);

    logic             valid_o;
    logic             ready_i;
    logic [Width-1:0] rs1_value_o;
    logic [Width-1:0] rs2_value_o;
    logic [Width-1:0] imm_o;
    logic [Width-1:0] pc_o;
    logic [AddrW-1:0] rd_addr_o;
    logic             is_load_o;

    modport master (
        output valid_o,
        input  ready_i,
        output rs1_value_o,
        output rs2_value_o,
        output imm_o,
        output pc_o,
        output rd_addr_o,
        output is_load_o
    );

    modport slave (
        input  valid_o,
        output ready_i,
        input  rs1_value_o,
        input  rs2_value_o,
        input  imm_o,
        input  pc_o,
        input  rd_addr_o,
        input  is_load_o
    );

endinterface : panda_operand_stage_if

// File: rtl/panda_operand_forward.sv
// ---------------------------------------------------------------------------
// panda_operand_forward
// Resolves one source operand against the bypass network.
// Priority: x0 -> zero, then execute result (non-load only), then
// writeback data, then register file read data. The writeback bypass is
// needed because the register file write is not visible on a same-cycle
// read.
// Ports:
//   addr_i                         : source register index
//   ex_rd_i/ex_we_i/ex_load_i/ex_data_i : instruction in execute
//   wb_rd_i/wb_we_i/wb_data_i      : writeback port
//   rf_data_i                      : register file read data
//   value_o                        : resolved operand
//   src_o                          : path that supplied value_o
// ---------------------------------------------------------------------------
module panda_operand_forward
    import panda_pkg::*;
#(
    parameter int Width = 32,
    parameter int AddrW = 5
) (
    input  logic [AddrW-1:0] addr_i,
    input  logic [AddrW-1:0] ex_rd_i,
    input  logic             ex_we_i,
    input  logic             ex_load_i,
    input  logic [Width-1:0] ex_data_i,
    input  logic [AddrW-1:0] wb_rd_i,
    input  logic             wb_we_i,
    input  logic [Width-1:0] wb_data_i,
    input  logic [Width-1:0] rf_data_i,
    output logic [Width-1:0] value_o,
    output src_sel_e         src_o
);

    // A load in execute has no data yet; the hazard logic in the top stalls
    // for that case, so it is simply excluded from the execute bypass here.
    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = ex_we_i & ~ex_load_i & (ex_rd_i == addr_i);
    assign w_wb_hit = wb_we_i & (wb_rd_i == addr_i);

    always_comb begin
        src_o = SrcRf;
        if (addr_i == '0) begin
            src_o = SrcZero;
        end else if (w_ex_hit) begin
            src_o = SrcEx;
        end else if (w_wb_hit) begin
            src_o = SrcWb;
        end
    end

    always_comb begin
        value_o = rf_data_i;
        unique case (src_o)
            SrcZero: value_o = '0;
            SrcEx:   value_o = ex_data_i;
            SrcWb:   value_o = wb_data_i;
            SrcRf:   value_o = rf_data_i;
            default: value_o = rf_data_i;
        endcase
    end

endmodule : panda_operand_forward

// File: rtl/panda_operand_stage.sv
// ---------------------------------------------------------------------------
// panda_operand_stage
// ID/EX boundary of the Panda pipeline. Drives register file read
// addresses, resolves both operands through the bypass network, detects
// load-use hazards (stall + one bubble) and registers the instruction
// toward execute.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   flush_i            : kill held and incoming instruction
//   valid_i / ready_o  : decoder handshake
//   rs1/rs2_addr_i, rs1/rs2_used_i, rd_addr_i, is_load_i, imm_i, pc_i
//                      : decoded instruction fields
//   rf_rs1/2_addr_o, rf_rs1/2_data_i : register file read ports
//   ex_*               : instruction in execute (bypass + hazard)
//   wb_*               : writeback port (bypass)
//   ex_if              : registered instruction toward execute
//   rs1_src_o/rs2_src_o: operand source select of the incoming instruction
// ---------------------------------------------------------------------------
module panda_operand_stage
    import panda_pkg::*;
#(
    parameter  int Width = 32,
    parameter  int Depth = 32,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,

    input  logic             valid_i,
    output logic             ready_o,
    input  logic [AddrW-1:0] rs1_addr_i,
    input  logic [AddrW-1:0] rs2_addr_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic [AddrW-1:0] rd_addr_i,
    input  logic             is_load_i,
    input  logic [Width-1:0] imm_i,
    input  logic [Width-1:0] pc_i,

    output logic [AddrW-1:0] rf_rs1_addr_o,
    output logic [AddrW-1:0] rf_rs2_addr_o,
    input  logic [Width-1:0] rf_rs1_data_i,
    input  logic [Width-1:0] rf_rs2_data_i,

    input  logic [AddrW-1:0] ex_rd_i,
    input  logic             ex_we_i,
    input  logic             ex_load_i,
    input  logic [Width-1:0] ex_data_i,

    input  logic [AddrW-1:0] wb_rd_i,
    input  logic             wb_we_i,
    input  logic [Width-1:0] wb_data_i,

    panda_operand_stage_if.master ex_if,

    output src_sel_e         rs1_src_o,
    output src_sel_e         rs2_src_o
);

    logic             r_valid;
    logic [Width-1:0] r_rs1_value;
    logic [Width-1:0] r_rs2_value;
    logic [Width-1:0] r_imm;
    logic [Width-1:0] r_pc;
    logic [AddrW-1:0] r_rd_addr;
    logic             r_is_load;

    logic [Width-1:0] w_rs1_value;
    logic [Width-1:0] w_rs2_value;
    logic             w_hazard;
    logic             w_can_advance;
    logic             w_accept;

    assign rf_rs1_addr_o = rs1_addr_i;
    assign rf_rs2_addr_o = rs2_addr_i;

    panda_operand_forward #(
        .Width (Width),
        .AddrW (AddrW)
    ) u_fwd_rs1 (
        .addr_i    (rs1_addr_i),
        .ex_rd_i   (ex_rd_i),
        .ex_we_i   (ex_we_i),
        .ex_load_i (ex_load_i),
        .ex_data_i (ex_data_i),
        .wb_rd_i   (wb_rd_i),
        .wb_we_i   (wb_we_i),
        .wb_data_i (wb_data_i),
        .rf_data_i (rf_rs1_data_i),
        .value_o   (w_rs1_value),
        .src_o     (rs1_src_o)
    );

    panda_operand_forward #(
        .Width (Width),
        .AddrW (AddrW)
    ) u_fwd_rs2 (
        .addr_i    (rs2_addr_i),
        .ex_rd_i   (ex_rd_i),
        .ex_we_i   (ex_we_i),
        .ex_load_i (ex_load_i),
        .ex_data_i (ex_data_i),
        .wb_rd_i   (wb_rd_i),
        .wb_we_i   (wb_we_i),
        .wb_data_i (wb_data_i),
        .rf_data_i (rf_rs2_data_i),
        .value_o   (w_rs2_value),
        .src_o     (rs2_src_o)
    );

    // Load in execute whose result a used source needs: hold the decoder one
    // cycle; the load then sits in writeback and the wb bypass supplies it.
    assign w_hazard = valid_i & ex_we_i & ex_load_i & (ex_rd_i != '0) &
                      ((rs1_used_i & (rs1_addr_i == ex_rd_i)) |
                       (rs2_used_i & (rs2_addr_i == ex_rd_i)));

    // Output register is free when empty or being drained this cycle.
    assign w_can_advance = ~r_valid | ex_if.ready_i;
    assign ready_o       = ~flush_i & ~w_hazard & w_can_advance;
    assign w_accept      = valid_i & ready_o;

    // Valid bit: flush wins; otherwise, when the register can advance it
    // takes the accept (hazard / no-input both yield a bubble); else hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_can_advance) begin
            r_valid <= w_accept;
        end
    end

    // Payload loads only on accept, so operands stay frozen during a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rs1_value <= '0;
            r_rs2_value <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_rd_addr   <= '0;
            r_is_load   <= 1'b0;
        end else if (w_accept) begin
            r_rs1_value <= w_rs1_value;
            r_rs2_value <= w_rs2_value;
            r_imm       <= imm_i;
            r_pc        <= pc_i;
            r_rd_addr   <= rd_addr_i;
            r_is_load   <= is_load_i;
        end
    end

    assign ex_if.valid_o     = r_valid;
    assign ex_if.rs1_value_o = r_rs1_value;
    assign ex_if.rs2_value_o = r_rs2_value;
    assign ex_if.imm_o       = r_imm;
    assign ex_if.pc_o        = r_pc;
    assign ex_if.rd_addr_o   = r_rd_addr;
    assign ex_if.is_load_o   = r_is_load;

endmodule : panda_operand_stage

// File: tb/tb_panda_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_panda_operand_stage
// Directed test of the Panda operand stage: reset, bypass priority,
// load-use stall, stall hold, flush and no-input bubble.
// ---------------------------------------------------------------------------
module tb_panda_operand_stage;
    import panda_pkg::*;

    localparam int Width = 32;
    localparam int AddrW = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [AddrW-1:0] rs1_addr_i;
    logic [AddrW-1:0] rs2_addr_i;
    logic             rs1_used_i;
    logic             rs2_used_i;
    logic [AddrW-1:0] rd_addr_i;
    logic             is_load_i;
    logic [Width-1:0] imm_i;
    logic [Width-1:0] pc_i;
    logic [AddrW-1:0] rf_rs1_addr_o;
    logic [AddrW-1:0] rf_rs2_addr_o;
    logic [Width-1:0] rf_rs1_data_i;
    logic [Width-1:0] rf_rs2_data_i;
    logic [AddrW-1:0] ex_rd_i;
    logic             ex_we_i;
    logic             ex_load_i;
    logic [Width-1:0] ex_data_i;
    logic [AddrW-1:0] wb_rd_i;
    logic             wb_we_i;
    logic [Width-1:0] wb_data_i;
    src_sel_e         rs1_src_o;
    src_sel_e         rs2_src_o;

    int checks = 0;
    int passes = 0;

    panda_operand_stage_if ex_if ();

    panda_operand_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_addr_i     (rd_addr_i),
        .is_load_i     (is_load_i),
        .imm_i         (imm_i),
        .pc_i          (pc_i),
        .rf_rs1_addr_o (rf_rs1_addr_o),
        .rf_rs2_addr_o (rf_rs2_addr_o),
        .rf_rs1_data_i (rf_rs1_data_i),
        .rf_rs2_data_i (rf_rs2_data_i),
        .ex_rd_i       (ex_rd_i),
        .ex_we_i       (ex_we_i),
        .ex_load_i     (ex_load_i),
        .ex_data_i     (ex_data_i),
        .wb_rd_i       (wb_rd_i),
        .wb_we_i       (wb_we_i),
        .wb_data_i     (wb_data_i),
        .ex_if         (ex_if),
        .rs1_src_o     (rs1_src_o),
        .rs2_src_o     (rs2_src_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [Width-1:0] obs,
                       input logic [Width-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        valid_i       = 1'b0;
        rs1_addr_i    = '0;
        rs2_addr_i    = '0;
        rs1_used_i    = 1'b0;
        rs2_used_i    = 1'b0;
        rd_addr_i     = '0;
        is_load_i     = 1'b0;
        imm_i         = '0;
        pc_i          = '0;
        rf_rs1_data_i = '0;
        rf_rs2_data_i = '0;
        ex_rd_i       = '0;
        ex_we_i       = 1'b0;
        ex_load_i     = 1'b0;
        ex_data_i     = '0;
        wb_rd_i       = '0;
        wb_we_i       = 1'b0;
        wb_data_i     = '0;
        ex_if.ready_i = 1'b1;
    endtask

    task automatic drive_instr(input logic [AddrW-1:0] a1, input logic [AddrW-1:0] a2,
                               input logic [Width-1:0] d1, input logic [Width-1:0] d2,
                               input logic [AddrW-1:0] rd, input logic ld,
                               input logic [Width-1:0] imm, input logic [Width-1:0] pc);
        valid_i       = 1'b1;
        rs1_addr_i    = a1;
        rs2_addr_i    = a2;
        rs1_used_i    = 1'b1;
        rs2_used_i    = 1'b1;
        rf_rs1_data_i = d1;
        rf_rs2_data_i = d2;
        rd_addr_i     = rd;
        is_load_i     = ld;
        imm_i         = imm;
        pc_i          = pc;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        chk("rst_valid", ex_if.valid_o, 0);
        chk("rst_rs1", ex_if.rs1_value_o, 0);
        chk("rst_rs2", ex_if.rs2_value_o, 0);
        chk("rst_imm", ex_if.imm_o, 0);
        chk("rst_pc", ex_if.pc_o, 0);
        chk("rst_rd", ex_if.rd_addr_o, 0);
        chk("rst_isload", ex_if.is_load_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // first accept after release
        drive_instr(5'd1, 5'd2, 32'h1111_0001, 32'h22, 5'd7, 1'b1, 32'h100, 32'h400);
        #1;
        chk("t1_ready", ready_o, 1);
        chk("t1_rfaddr1", rf_rs1_addr_o, 1);
        chk("t1_rfaddr2", rf_rs2_addr_o, 2);
        tick();
        chk("t1_valid", ex_if.valid_o, 1);
        chk("t1_rs1", ex_if.rs1_value_o, 32'h1111_0001);
        chk("t1_rs2", ex_if.rs2_value_o, 32'h22);
        chk("t1_imm", ex_if.imm_o, 32'h100);
        chk("t1_pc", ex_if.pc_o, 32'h400);
        chk("t1_rd", ex_if.rd_addr_o, 7);
        chk("t1_isload", ex_if.is_load_o, 1);

        // reset mid-stream drops the held instruction
        rst_ni = 1'b0;
        #1;
        chk("t1_midrst_valid", ex_if.valid_o, 0);
        chk("t1_midrst_pc", ex_if.pc_o, 0);
        chk("t1_midrst_rs1", ex_if.rs1_value_o, 0);
        rst_ni = 1'b1;
        tick();
        chk("t1_reaccept_valid", ex_if.valid_o, 1);
        chk("t1_reaccept_pc", ex_if.pc_o, 32'h400);

        // ---------------- bypass priority ----------------
        drive_instr(5'd3, 5'd0, 32'h11, 32'h0, 5'd8, 1'b0, 32'h0, 32'h410);
        ex_we_i = 1'b1; ex_rd_i = 5'd3; ex_data_i = 32'hAA;
        wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hBB;
        #1;
        chk("t2_ex_src", rs1_src_o, SrcEx);
        chk("t2_ex_ready", ready_o, 1);
        tick();
        chk("t2_ex_rs1", ex_if.rs1_value_o, 32'hAA);
        ex_we_i = 1'b0;
        tick();
        chk("t2_wb_rs1", ex_if.rs1_value_o, 32'hBB);
        wb_we_i = 1'b0;
        tick();
        chk("t2_rf_rs1", ex_if.rs1_value_o, 32'h11);
        rs1_addr_i = 5'd0;
        ex_we_i = 1'b1; ex_rd_i = 5'd0;
        wb_we_i = 1'b1; wb_rd_i = 5'd0;
        tick();
        chk("t2_x0_rs1", ex_if.rs1_value_o, 0);
        chk("t2_x0_src", rs1_src_o, SrcZero);

        // ---------------- load-use hazard ----------------
        idle_inputs();
        drive_instr(5'd0, 5'd5, 32'h0, 32'hDEAD, 5'd9, 1'b0, 32'h0, 32'h420);
        ex_we_i = 1'b1; ex_load_i = 1'b1; ex_rd_i = 5'd5;
        #1;
        chk("t3_hazard_ready", ready_o, 0);
        tick();
        chk("t3_bubble_valid", ex_if.valid_o, 0);
        // load has moved to writeback
        ex_we_i = 1'b0; ex_load_i = 1'b0; ex_rd_i = 5'd0;
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
        #1;
        chk("t3_after_ready", ready_o, 1);
        tick();
        chk("t3_after_valid", ex_if.valid_o, 1);
        chk("t3_after_rs2", ex_if.rs2_value_o, 32'h1234);
        chk("t3_after_pc", ex_if.pc_o, 32'h420);

        // ---------------- no hazard cases ----------------
        wb_we_i = 1'b0;
        ex_we_i = 1'b1; ex_load_i = 1'b1; ex_rd_i = 5'd5;
        rs2_used_i = 1'b0;
        #1;
        chk("t4_unused_ready", ready_o, 1);
        rs2_used_i = 1'b1;
        ex_rd_i = 5'd0; rs2_addr_i = 5'd0;
        #1;
        chk("t4_x0_ready", ready_o, 1);

        // no-input cycle drains the register
        idle_inputs();
        tick();
        chk("t4_noinput_valid", ex_if.valid_o, 0);

        // ---------------- stall hold ----------------
        drive_instr(5'd4, 5'd0, 32'h44, 32'h0, 5'd9, 1'b0, 32'h50, 32'h500);
        tick();
        chk("t5_a_valid", ex_if.valid_o, 1);
        ex_if.ready_i = 1'b0;
        drive_instr(5'd6, 5'd0, 32'h66, 32'h0, 5'd10, 1'b0, 32'h60, 32'h600);
        for (int i = 0; i < 3; i++) begin
            ex_we_i = 1'b1; ex_rd_i = 5'd4; ex_data_i = 32'hF00 + i;
            wb_we_i = 1'b1; wb_rd_i = 5'd4; wb_data_i = 32'hE00 + i;
            #1;
            chk("t5_stall_ready", ready_o, 0);
            tick();
            chk("t5_stall_valid", ex_if.valid_o, 1);
            chk("t5_stall_rs1", ex_if.rs1_value_o, 32'h44);
            chk("t5_stall_pc", ex_if.pc_o, 32'h500);
            chk("t5_stall_imm", ex_if.imm_o, 32'h50);
            chk("t5_stall_rd", ex_if.rd_addr_o, 9);
        end
        ex_we_i = 1'b0; wb_we_i = 1'b0;
        ex_if.ready_i = 1'b1;
        #1;
        chk("t5_release_ready", ready_o, 1);
        tick();
        chk("t5_b_valid", ex_if.valid_o, 1);
        chk("t5_b_pc", ex_if.pc_o, 32'h600);
        chk("t5_b_rs1", ex_if.rs1_value_o, 32'h66);
        chk("t5_b_rd", ex_if.rd_addr_o, 10);

        // ---------------- flush ----------------
        ex_if.ready_i = 1'b0;
        drive_instr(5'd5, 5'd0, 32'h77, 32'h0, 5'd11, 1'b0, 32'h70, 32'h700);
        ex_we_i = 1'b1; ex_load_i = 1'b1; ex_rd_i = 5'd5;
        flush_i = 1'b1;
        #1;
        chk("t6_flush_ready", ready_o, 0);
        tick();
        chk("t6_flush_valid", ex_if.valid_o, 0);
        idle_inputs();
        tick();
        chk("t6_idle_valid", ex_if.valid_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_panda_operand_stage

// File: doc/panda_operand_stage.md
Name: panda_operand_stage

Overview:
- ID/EX boundary stage of the Panda pipeline.
- Drives the register file read addresses from the decoded instruction and resolves RAW hazards, with x0 handled as zero.
- Captures the resolved operands, immediate, PC and rd into a pipeline register toward execute.
- Detects load-use hazards, stalls the decoder and inserts a single bubble.

Parameters:
Width, 32, data/operand width in bits
Depth, 32, number of architectural registers; AddrW = $clog2(Depth)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
flush_i  in  1  kill held and incoming instruction (branch/jump redirect)
valid_i  in  1  decoder presents an instruction
ready_o  out  1  stage accepts instruction this cycle
rs1_addr_i  in  AddrW  source 1 index
rs2_addr_i  in  AddrW  source 2 index
rs1_used_i  in  1  instruction reads rs1
rs2_used_i  in  1  instruction reads rs2
rd_addr_i  in  AddrW  destination index
is_load_i  in  1  instruction is a load
imm_i  in  Width  decoded immediate
pc_i  in  Width  instruction PC
rf_rs1_addr_o  out  AddrW  register file read port 1 address (= rs1_addr_i)
rf_rs2_addr_o  out  AddrW  register file read port 2 address (= rs2_addr_i)
rf_rs1_data_i  in  Width  register file read data 1
rf_rs2_data_i  in  Width  register file read data 2
ex_rd_i  in  AddrW  rd of instruction one stage ahead (in execute)
ex_we_i  in  1  that instruction writes rd
ex_load_i  in  1  that instruction is a load (result not yet available)
ex_data_i  in  Width  its ALU result
wb_rd_i  in  AddrW  writeback rd (same as register file write port)
wb_we_i  in  1  writeback write enable
wb_data_i  in  Width  writeback data
valid_o  out  1  output register holds a live instruction
ready_i  in  1  execute accepts
rs1_value_o  out  Width  resolved operand 1
rs2_value_o  out  Width  resolved operand 2
imm_o  out  Width  registered immediate
pc_o  out  Width  registered PC
rd_addr_o  out  AddrW  registered rd
is_load_o  out  1  registered load flag

Behaviour:
- Reset (async, rst_ni low): valid_o=0; all data outputs 0. Reset mid-stall drops the held instruction.
- Pipeline register handshake:
  - Transfer out when valid_o & ready_i.
  - Accept when valid_i & ready_o; captured values appear on outputs the next cycle (latency 1).
  - ready_o = ~flush_i & ~hazard & (~valid_o | ready_i).
- Load-use hazard:
  - hazard = valid_i & ex_we_i & ex_load_i & (ex_rd_i != 0) & ((rs1_used_i & rs1_addr_i==ex_rd_i) | (rs2_used_i & rs2_addr_i==ex_rd_i)).
  - On hazard with (~valid_o | ready_i): valid_o<=0 (one bubble).
  - On the next cycle the load has advanced, so the value forwards from writeback.
- Operand resolution (combinational, per source, priority order):
  - addr==0 -> 0.
  - ex_we_i & ~ex_load_i & ex_rd_i==addr -> ex_data_i.
  - wb_we_i & wb_rd_i==addr -> wb_data_i. The register file write is not visible on the same-cycle read, so this path is mandatory.
  - Otherwise rf data.
- Stall hold: while valid_o & ~ready_i, every output is held stable. Operands are frozen at capture and are not re-resolved.
- Flush:
  - flush_i dominates stall and hazard: valid_o<=0 next cycle.
  - Incoming instruction is not accepted (ready_o=0).
  - Data regs may retain stale values.
- No-input cycle: when (~valid_o | ready_i) & ~valid_i, valid_o<=0.
- Data registers load only on accept; valid bit updated every cycle per the rules above.

Decomposition:
- panda_pkg holds the operand-source select enum: SrcZero, SrcEx, SrcWb, SrcRf.
- One sub-module, panda_operand_forward, instantiated twice (rs1, rs2).
  - Inputs: address, the ex/wb bypass inputs and rf data.
  - Outputs: resolved value and source select.
- Hazard detect and the pipeline register stay in the top module.

Test Plan:
1. Reset with rst_ni low mid-stream -> valid_o=0 and all outputs 0; first accept after release gives valid_o=1 one cycle later.
2. rf_rs1_data_i=0x11, rs1_addr_i=3, ex_we_i=1, ex_rd_i=3, ex_data_i=0xAA, wb_rd_i=3, wb_data_i=0xBB -> rs1_value_o=0xAA. With ex_we_i=0 -> 0xBB. With rs1_addr_i=0 and all bypasses matching 0 -> 0.
3. ex_load_i=1, ex_rd_i=5, rs2_addr_i=5, rs2_used_i=1 -> ready_o=0 and a bubble (valid_o=0). Next cycle wb_rd_i=5, wb_data_i=0x1234 -> accepted with rs2_value_o=0x1234.
4. Load hazard with rs2_used_i=0, or ex_rd_i=0 -> no stall; ready_o=1.
5. valid_o=1 and ready_i=0 for 3 cycles while bypass inputs change -> outputs constant, ready_o=0. ready_i=1 -> next queued instruction appears the following cycle.
6. flush_i=1 together with valid_i=1 and a pending hazard -> ready_o=0, and valid_o=0 next cycle.
